// File: rtl/cpu_clock_ctrl_if.sv
// cpu_clock_ctrl_if: raw operator/CPU inputs and the generated CPU clock phase outputs.
interface cpu_clock_ctrl_if;
  logic mode;
  logic button;
  logic halt;
  logic cpu_clk;
  logic clk_rise;
  logic clk_fall;
  logic halted;
  logic btn_db;
  modport master (output mode, button, halt, input cpu_clk, clk_rise, clk_fall, halted, btn_db);
  modport slave (input mode, button, halt, output cpu_clk, clk_rise, clk_fall, halted, btn_db);
endinterface

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: debounced step/continuous CPU clock phase generator with halt support.
// CPU logic advances on clk_rise enables; cpu_clk is a display level only.
module cpu_clock_ctrl #(
  parameter int HALF_PERIOD     = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 24
) (
  input  logic             i_sys_clk,
  input  logic             i_rst_n,
  cpu_clock_ctrl_if.slave  bus
);
  typedef enum logic {IDLE, HIGH} state_t;
  localparam logic [CNT_W-1:0] HP_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic             r_btn_m, r_btn_s, r_mode_m, r_mode_s;
  logic             r_btn_db, r_btn_q;
  logic [CNT_W-1:0] r_dcnt;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_cpu_clk, w_clk_nxt;
  logic             r_rise, w_rise_nxt;
  logic             r_fall, w_fall_nxt;
  logic             r_act, w_act_nxt;
  logic             r_halted;
  logic             w_press, w_mode_chg, w_at_last;
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_btn_m  <= 1'b0;
      r_btn_s  <= 1'b0;
      r_mode_m <= 1'b0;
      r_mode_s <= 1'b0;
      r_btn_db <= 1'b0;
      r_btn_q  <= 1'b0;
      r_dcnt   <= '0;
    end else begin
      r_btn_m  <= bus.button;
      r_btn_s  <= r_btn_m;
      r_mode_m <= bus.mode;
      r_mode_s <= r_mode_m;
      r_btn_q  <= r_btn_db;
      if (r_btn_s == r_btn_db) r_dcnt <= '0;
      else if (r_dcnt == DB_LAST) begin
        r_btn_db <= r_btn_s;
        r_dcnt   <= '0;
      end else r_dcnt <= r_dcnt + CNT_W'(1);
    end
  end
  assign w_press    = r_btn_db & ~r_btn_q;
  assign w_at_last  = r_cnt == HP_LAST;
  // mode may only change while parked low so no runt phase is ever produced
  assign w_mode_chg = ~r_cpu_clk & (r_state == IDLE) & (r_mode_s != r_act);
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clk_nxt   = r_cpu_clk;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_act_nxt   = r_act;
    if (w_mode_chg) begin
      w_act_nxt = r_mode_s;
      w_cnt_nxt = '0;
    end else if (r_act) begin
      if (r_state == HIGH) begin
        w_cnt_nxt = w_at_last ? '0 : r_cnt + CNT_W'(1);
        if (w_at_last) begin
          w_state_nxt = IDLE;
          w_clk_nxt   = 1'b0;
          w_fall_nxt  = 1'b1;
        end
      end else begin
        w_cnt_nxt = '0;
        if (w_press & ~bus.halt) begin
          w_state_nxt = HIGH;
          w_clk_nxt   = 1'b1;
          w_rise_nxt  = 1'b1;
        end
      end
    end else if (~r_cpu_clk & bus.halt) begin
      w_cnt_nxt = '0;
    end else if (w_at_last) begin
      w_cnt_nxt  = '0;
      w_clk_nxt  = ~r_cpu_clk;
      w_rise_nxt = ~r_cpu_clk;
      w_fall_nxt = r_cpu_clk;
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_cpu_clk <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_act     <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cpu_clk <= w_clk_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
      r_act     <= w_act_nxt;
      r_halted  <= ~r_cpu_clk & bus.halt;
    end
  end
  assign bus.cpu_clk  = r_cpu_clk;
  assign bus.clk_rise = r_rise;
  assign bus.clk_fall = r_fall;
  assign bus.halted   = r_halted;
  assign bus.btn_db   = r_btn_db;
endmodule
